// File: rtl/cgra_cfg_pkg.sv
// Shared types and helpers for the CGRA configuration loader.
package cgra_cfg_pkg;

    localparam int unsigned CFG_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cfg_ld_state_e;

    // Rotate left by one, then fold the bit just shifted onto the chain into bit 0.
    function automatic logic [CFG_WORD_W-1:0] cfg_checksum_next(
        input logic [CFG_WORD_W-1:0] cs,
        input logic                  b
    );
        return {cs[CFG_WORD_W-2:0], cs[CFG_WORD_W-1]} ^ {{(CFG_WORD_W-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one bitstream word and shifts it out LSB-first, one bit per enabled cycle.
module cfg_word_serializer
    import cgra_cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  en,
    input  logic                  last_bit,
    input  logic [CFG_WORD_W-1:0] data,
    output logic                  bit_out,
    output logic                  full,
    output logic                  consume
);

    logic [CFG_WORD_W-1:0] shreg;
    logic [4:0]            widx;

    // A word is finished at its last bit, or early when the chain itself ends.
    assign consume = en && ((widx == 5'd31) || last_bit);
    assign bit_out = shreg[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            full  <= 1'b0;
            widx  <= '0;
        end else if (clear) begin
            shreg <= '0;
            full  <= 1'b0;
            widx  <= '0;
        end else if (load) begin
            shreg <= data;
            full  <= 1'b1;
            widx  <= '0;
        end else if (consume) begin
            shreg <= shreg >> 1;
            full  <= 1'b0;
            widx  <= '0;
        end else if (en) begin
            shreg <= shreg >> 1;
            widx  <= widx + 5'd1;
        end
    end

endmodule

// File: rtl/cgra_config_loader.sv
// Word-to-serial loader for the CGRA config chain; holds the fabric in reset until loaded.
// Optional running checksum enabled by defining CFG_LOADER_CHECKSUM_EN.
module cgra_config_loader
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 512,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              Config_Clock,
    input  logic              Config_Reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              cfg_bit,
    output logic              cfg_clk_en,
    output logic              busy,
    output logic              done,
    output logic              cgra_hold,
    output logic [31:0]       checksum
);

    localparam int unsigned          CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    cfg_ld_state_e    state;
    logic [CNT_W-1:0] bit_cnt;
    logic             full;
    logic             consume;
    logic             shift_en;
    logic             last_bit;
    logic             enter_load;

    assign enter_load = start && !abort && (state != LOAD);
    assign shift_en   = (state == LOAD) && full;
    assign last_bit   = (bit_cnt == LAST_BIT);
    assign cfg_clk_en = shift_en;
    assign in_ready   = (state == LOAD) && (!full || consume);

    cfg_word_serializer u_ser (
        .clk      (Config_Clock),
        .rst_n    (Config_Reset),
        .clear    (enter_load),
        .load     (in_valid && in_ready),
        .en       (shift_en),
        .last_bit (last_bit),
        .data     (in_data),
        .bit_out  (cfg_bit),
        .full     (full),
        .consume  (consume)
    );

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cgra_hold <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (enter_load) begin
                        state     <= LOAD;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        cgra_hold <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        cgra_hold <= 1'b1;
                    end else if (shift_en) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (last_bit) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cgra_hold <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    cgra_hold <= 1'b1;
                end
            endcase
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [31:0] cs_q;

    always_ff @(posedge Config_Clock or negedge Config_Reset) begin
        if (!Config_Reset) begin
            cs_q <= '0;
        end else if (enter_load) begin
            cs_q <= '0;
        end else if (shift_en) begin
            cs_q <= cfg_checksum_next(cs_q, cfg_bit);
        end
    end

    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader: three instances with chain lengths 40, 64 and 32.
module tb_cgra_config_loader;

    logic        Config_Clock = 1'b0;
    logic        Config_Reset = 1'b1;
    logic [2:0]  start        = '0;
    logic [2:0]  abort        = '0;
    logic [2:0]  in_valid     = '0;
    logic [31:0] in_data [3];
    logic [2:0]  in_ready, cfg_bit, cfg_clk_en, busy, done, cgra_hold;
    logic [31:0] checksum [3];

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CFG_LOADER_CHECKSUM_EN
    localparam logic [31:0] CS_EXP = 32'h8000_0000;
`else
    localparam logic [31:0] CS_EXP = 32'h0000_0000;
`endif

    always #5 Config_Clock = ~Config_Clock;

    cgra_config_loader #(.CHAIN_LEN(40)) dut0 (
        .Config_Clock(Config_Clock), .Config_Reset(Config_Reset),
        .start(start[0]), .abort(abort[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
        .in_ready(in_ready[0]), .cfg_bit(cfg_bit[0]), .cfg_clk_en(cfg_clk_en[0]),
        .busy(busy[0]), .done(done[0]), .cgra_hold(cgra_hold[0]), .checksum(checksum[0]));

    cgra_config_loader #(.CHAIN_LEN(64)) dut1 (
        .Config_Clock(Config_Clock), .Config_Reset(Config_Reset),
        .start(start[1]), .abort(abort[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
        .in_ready(in_ready[1]), .cfg_bit(cfg_bit[1]), .cfg_clk_en(cfg_clk_en[1]),
        .busy(busy[1]), .done(done[1]), .cgra_hold(cgra_hold[1]), .checksum(checksum[1]));

    cgra_config_loader #(.CHAIN_LEN(32)) dut2 (
        .Config_Clock(Config_Clock), .Config_Reset(Config_Reset),
        .start(start[2]), .abort(abort[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
        .in_ready(in_ready[2]), .cfg_bit(cfg_bit[2]), .cfg_clk_en(cfg_clk_en[2]),
        .busy(busy[2]), .done(done[2]), .cgra_hold(cgra_hold[2]), .checksum(checksum[2]));

    task automatic do_start(input int d);
        @(negedge Config_Clock);
        start[d] = 1'b1;
        @(negedge Config_Clock);
        start[d] = 1'b0;
    endtask

    // Feeds up to two words, recording every enabled-cycle bit; optional withheld gap
    // before word 2 and an optional start/abort pulse once ev_at bits have shifted.
    task automatic run_load(
        input  int          d,
        input  logic [31:0] w0,
        input  logic [31:0] w1,
        input  int          nw,
        input  int          gap,
        input  int          ev_at,
        input  logic        ev_start,
        input  logic        ev_abort,
        output logic [63:0] bits,
        output int          nen,
        output int          max_run,
        output int          rdy_first,
        output int          rdy_cnt,
        output int          starve_bad,
        output logic        done_seen,
        output logic        last_was_en
    );
        int   wi      = 0;
        int   gapc    = 0;
        int   run     = 0;
        logic starved = 1'b0;
        logic ev_done = 1'b0;
        bits = '0; nen = 0; max_run = 0; rdy_first = -1; rdy_cnt = 0;
        starve_bad = 0; done_seen = 1'b0; last_was_en = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done[d] === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            if (starved) begin
                if (cfg_clk_en[d] !== 1'b0) starve_bad++;
                if (d == 0 && dut0.bit_cnt !== 6'd32) starve_bad++;
            end
            last_was_en = cfg_clk_en[d];
            if (cfg_clk_en[d] === 1'b1) begin
                if (in_ready[d] === 1'b1) begin
                    if (rdy_first < 0) rdy_first = nen;
                    rdy_cnt++;
                end
                if (nen < 64) bits[nen] = cfg_bit[d];
                nen++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            start[d] = 1'b0;
            abort[d] = 1'b0;
            if (ev_at >= 0 && !ev_done && nen == ev_at) begin
                start[d] = ev_start;
                abort[d] = ev_abort;
                ev_done  = 1'b1;
                if (ev_abort) begin
                    in_valid[d] = 1'b0;
                    @(negedge Config_Clock);
                    start[d] = 1'b0;
                    abort[d] = 1'b0;
                    return;
                end
            end
            starved = 1'b0;
            if (wi < nw && !(wi == 1 && nen >= 32 && gapc < gap)) begin
                in_valid[d] = 1'b1;
                in_data[d]  = (wi == 0) ? w0 : w1;
                if (in_ready[d] === 1'b1) wi++;
            end else begin
                in_valid[d] = 1'b0;
                if (wi == 1 && nen >= 32 && gapc < gap) begin
                    gapc++;
                    starved = 1'b1;
                end
            end
            @(negedge Config_Clock);
        end
        in_valid[d] = 1'b0;
        start[d]    = 1'b0;
        abort[d]    = 1'b0;
    endtask

    task automatic test_reset();
        #2 Config_Reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_tests++;
            if ({in_ready[d], cfg_bit[d], cfg_clk_en[d], busy[d], done[d], cgra_hold[d]} !== 6'b000001
                || checksum[d] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got rdy/bit/en/busy/done/hold=%b%b%b%b%b%b cs=%h, expected 000001 cs=0",
                         d, in_ready[d], cfg_bit[d], cfg_clk_en[d], busy[d], done[d], cgra_hold[d], checksum[d]);
            end
        end
        repeat (2) @(negedge Config_Clock);
        Config_Reset = 1'b1;
    endtask

    task automatic check_full_load(input string name, input int d, input int exp_n,
                                   input logic [63:0] exp_bits, input logic [63:0] bits,
                                   input int nen, input logic done_seen, input logic last_was_en);
        logic [63:0] mask;
        mask = (exp_n == 64) ? '1 : ((64'd1 << exp_n) - 64'd1);
        n_tests++;
        if (done_seen !== 1'b1 || nen != exp_n) begin
            n_fail++;
            $display("FAIL %s_count: got done=%b enabled=%0d, expected done=1 enabled=%0d", name, done_seen, nen, exp_n);
        end
        n_tests++;
        if ((bits & mask) !== (exp_bits & mask)) begin
            n_fail++;
            $display("FAIL %s_bits: got %h, expected %h", name, bits & mask, exp_bits & mask);
        end
        n_tests++;
        if (last_was_en !== 1'b1 || cgra_hold[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done_state: got last_en=%b hold=%b busy=%b rdy=%b, expected 1 0 0 0",
                     name, last_was_en, cgra_hold[d], busy[d], in_ready[d]);
        end
    endtask

    task automatic test_basic_load();
        logic [63:0] bits; int nen, mr, rf, rc, sb; logic ds, le; int extra;
        do_start(0);
        n_tests++;
        if (busy[0] !== 1'b1 || in_ready[0] !== 1'b1 || cgra_hold[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: got busy=%b rdy=%b hold=%b, expected 1 1 1", busy[0], in_ready[0], cgra_hold[0]);
        end
        run_load(0, 32'hA5A5_A5A5, 32'h0000_00C3, 2, 0, -1, 1'b0, 1'b0, bits, nen, mr, rf, rc, sb, ds, le);
        check_full_load("basic", 0, 40, {24'h0, 8'hC3, 32'hA5A5_A5A5}, bits, nen, ds, le);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (cfg_clk_en[0] !== 1'b0 || done[0] !== 1'b1) extra++;
            @(negedge Config_Clock);
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL done_hold: got %0d cycles with enable or done dropped, expected 0", extra);
        end
`ifndef CFG_LOADER_CHECKSUM_EN
        n_tests++;
        if (checksum[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL checksum_tied: got %h, expected 00000000", checksum[0]);
        end
`endif
    endtask

    task automatic test_starvation();
        logic [63:0] bits; int nen, mr, rf, rc, sb; logic ds, le;
        do_start(0);
        run_load(0, 32'hA5A5_A5A5, 32'h5A5A_5AC3, 2, 10, -1, 1'b0, 1'b0, bits, nen, mr, rf, rc, sb, ds, le);
        check_full_load("starve", 0, 40, {24'h0, 8'hC3, 32'hA5A5_A5A5}, bits, nen, ds, le);
        n_tests++;
        if (sb != 0) begin
            n_fail++;
            $display("FAIL starve_hold: got %0d starved cycles with enable or bit_cnt moved, expected 0", sb);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits; int nen, mr, rf, rc, sb; logic ds, le;
        do_start(1);
        run_load(1, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 2, 0, -1, 1'b0, 1'b0, bits, nen, mr, rf, rc, sb, ds, le);
        check_full_load("b2b", 1, 64, {32'h3C3C_3C3C, 32'hA5A5_A5A5}, bits, nen, ds, le);
        n_tests++;
        if (mr != 64) begin
            n_fail++;
            $display("FAIL b2b_gapless: got longest enable run %0d, expected 64", mr);
        end
        n_tests++;
        if (rf != 31 || rc != 2) begin
            n_fail++;
            $display("FAIL b2b_ready: got first ready at bit %0d count %0d, expected bit 31 count 2", rf, rc);
        end
    endtask

    task automatic test_abort();
        logic [63:0] bits; int nen, mr, rf, rc, sb; logic ds, le;
        do_start(0);
        run_load(0, 32'hA5A5_A5A5, 32'h0000_00C3, 2, 0, 20, 1'b0, 1'b1, bits, nen, mr, rf, rc, sb, ds, le);
        n_tests++;
        if ({busy[0], cgra_hold[0], in_ready[0], done[0], cfg_clk_en[0]} !== 5'b01000) begin
            n_fail++;
            $display("FAIL abort_idle: got busy/hold/rdy/done/en=%b%b%b%b%b, expected 01000",
                     busy[0], cgra_hold[0], in_ready[0], done[0], cfg_clk_en[0]);
        end
        do_start(0);
        run_load(0, 32'h1234_5678, 32'h0000_0096, 2, 0, -1, 1'b0, 1'b0, bits, nen, mr, rf, rc, sb, ds, le);
        check_full_load("reload", 0, 40, {24'h0, 8'h96, 32'h1234_5678}, bits, nen, ds, le);
    endtask

    task automatic test_start_in_load();
        logic [63:0] bits; int nen, mr, rf, rc, sb; logic ds, le; int bad;
        do_start(0);
        run_load(0, 32'hDEAD_BEEF, 32'h0000_0071, 2, 0, 20, 1'b1, 1'b0, bits, nen, mr, rf, rc, sb, ds, le);
        check_full_load("start_ignored", 0, 40, {24'h0, 8'h71, 32'hDEAD_BEEF}, bits, nen, ds, le);
        do_start(0);
        run_load(0, 32'hDEAD_BEEF, 32'h0000_0071, 2, 0, 10, 1'b1, 1'b1, bits, nen, mr, rf, rc, sb, ds, le);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if ({busy[0], cgra_hold[0], done[0], cfg_clk_en[0]} !== 4'b0100) bad++;
            @(negedge Config_Clock);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL start_abort_same_cycle: got %0d cycles not idle, expected 0", bad);
        end
    endtask

    task automatic test_checksum();
        logic [63:0] bits; int nen, mr, rf, rc, sb; logic ds, le;
        do_start(2);
        run_load(2, 32'h0000_0001, 32'h0, 1, 0, -1, 1'b0, 1'b0, bits, nen, mr, rf, rc, sb, ds, le);
        check_full_load("cs_load", 2, 32, 64'h0000_0000_0000_0001, bits, nen, ds, le);
        n_tests++;
        if (checksum[2] !== CS_EXP) begin
            n_fail++;
            $display("FAIL checksum_value: got %h, expected %h", checksum[2], CS_EXP);
        end
    endtask

    task automatic test_async_reset();
        do_start(0);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'hFFFF_FFFF;
        repeat (5) @(negedge Config_Clock);
        #2 Config_Reset = 1'b0;
        #1;
        n_tests++;
        if ({in_ready[0], cfg_bit[0], cfg_clk_en[0], busy[0], done[0], cgra_hold[0]} !== 6'b000001
            || checksum[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_load: got rdy/bit/en/busy/done/hold=%b%b%b%b%b%b cs=%h, expected 000001 cs=0",
                     in_ready[0], cfg_bit[0], cfg_clk_en[0], busy[0], done[0], cgra_hold[0], checksum[0]);
        end
        n_tests++;
        if (done[1] !== 1'b0 || cgra_hold[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_done: got done=%b hold=%b, expected 0 1", done[1], cgra_hold[1]);
        end
        in_valid[0] = 1'b0;
        @(negedge Config_Clock);
        Config_Reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        test_reset();
        test_basic_load();
        test_starvation();
        test_back_to_back();
        test_abort();
        test_start_in_load();
        test_checksum();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cgra_config_loader.md
# cgra_config_loader

Word-to-serial configuration loader for the CGRA fabric's bit-serial configuration chain. Accepts 32-bit bitstream words over a valid/ready stream, shifts them one bit per enabled cycle onto the fabric's `ConfigIn`, and produces the clock-enable for the chain's clock gate. Holds the CGRA datapath in reset until exactly `CHAIN_LEN` bits have been shifted. Sits between the host-side MMIO/DMA bitstream source and the fabric top.

## Interface
- `CHAIN_LEN`, 512: total config-chain length in bits. The top sets this to the fabric's actual chain length. Legal range is ≥1.
- `WORD_W`, 32: input word width. Fixed at 32; other values are not supported.
- `Config_Clock` input 1: sole clock.
- `Config_Reset` input 1: reset, asynchronous, active-low.
- `start` input 1: single-cycle pulse that begins a load.
- `abort` input 1: cancels a load in progress.
- `in_valid` input 1: bitstream word valid.
- `in_data` input 32: bitstream word. Bit 0 is shifted first.
- `in_ready` output 1: loader can accept a word.
- `cfg_bit` output 1: drives the fabric's `ConfigIn`.
- `cfg_clk_en` output 1: enable for the config-chain clock gate. The chain advances one bit on each `Config_Clock` edge while this is high.
- `busy` output 1: high in the LOAD state.
- `done` output 1: high in the DONE state, i.e. the full chain is loaded.
- `cgra_hold` output 1: active-high request that drives the fabric's `CGRA_Reset`.
- `checksum` output 32: running checksum, described under Configuration.

## Operation
- States:
  - IDLE: entered from reset or abort.
  - LOAD
  - DONE
- IDLE → LOAD on `start`. Entry clears the bit counters and the word buffer.
- LOAD → DONE when the last bit (`bit_cnt == CHAIN_LEN-1`) is shifted.
- LOAD → IDLE on `abort`.
- DONE → LOAD on `start`, which performs a reload.
- `start` is ignored while in LOAD.
- `abort` takes priority over `start` and over shift completion in the same cycle.
- Datapath:
  - One 32-bit shift register `shreg`, plus a `full` flag.
  - 5-bit in-word index `widx`.
  - Total counter `bit_cnt` of width `$clog2(CHAIN_LEN+1)`.
- `cfg_bit = shreg[0]`.
- `cfg_clk_en = (state==LOAD) && full`.
- Per enabled cycle:
  - `shreg` shifts right by one.
  - `widx` and `bit_cnt` each increment by 1.
  - The word is consumed when `widx==31`, or when `bit_cnt==CHAIN_LEN-1`.
- `in_ready = (state==LOAD) && (!full || word_consumed_this_cycle)`. This gives back-to-back words with no bubble.
- Partial last word: `CHAIN_LEN mod 32` low bits are used. The remaining bits are discarded and `full` clears.
- Input starvation (LOAD, `!full`): `cfg_clk_en` is 0 and the chain holds. This is not an error.
- Words offered in IDLE or DONE are not accepted (`in_ready` is 0).
- `cgra_hold` is 1 in IDLE and LOAD, and 0 only in DONE.
- Abort mid-load leaves the chain partially written. `cgra_hold` stays 1 until a complete reload finishes.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`, `cfg_bit`, `cfg_clk_en`, `busy`, `done` are 0.
  - `cgra_hold` is 1.
  - `checksum` is 0.
  - `shreg` is 0 and `full` is 0.
- All outputs are registered or decoded only from registered state. There are no input→output combinational paths, except `in_ready`'s dependence on the consume condition, which uses registered `widx`/`bit_cnt` only.
- Latency:
  - `start` at edge N gives `busy`=1 after N.
  - The first word is accepted at edge M.
  - The first enabled cycle is the cycle after M.
- Load time: `CHAIN_LEN` cycles with gapless input, plus 1 cycle.
- `done` and `cgra_hold`=0 are visible the cycle after the final enabled cycle.
- Reset mid-operation aborts immediately and asynchronously to the reset values.

## Configuration
- Macro: `CFG_LOADER_CHECKSUM_EN`.
- When defined:
  - `checksum` clears on entry to LOAD.
  - On each enabled cycle: `checksum <= {checksum[30:0], checksum[31]} ^ {31'b0, cfg_bit}`.
  - The value is held in DONE and IDLE.
- When undefined: `checksum` is tied to 0 and no checksum register is synthesised.

## Structure
- Package `cgra_cfg_pkg`:
  - State enum `cfg_ld_state_e` (IDLE/LOAD/DONE).
  - `CFG_WORD_W=32`.
  - The checksum update function.
- One natural sub-module: `cfg_word_serializer`, which holds `shreg`, `full` and `widx`, and produces `bit_out`/`consume`. The FSM and `bit_cnt` stay in the top.

## Test plan
- Reset, then `CHAIN_LEN`=40, `start`, words `0xA5A5A5A5` and `0x000000C3` offered continuously:
  - `cfg_bit` over 40 enabled cycles equals `0xA5A5A5A5` LSB-first, then `0xC3` LSB-first.
  - `done`=1 and `cgra_hold`=0 follow exactly 40 enabled cycles.
  - Word 2 bits [31:8] are discarded.
- Starvation: hold `in_valid`=0 for 10 cycles between words.
  - `cfg_clk_en`=0 for those cycles.
  - Total enabled cycles is still 40.
  - `bit_cnt` is unchanged across the gap.
- Back-to-back: `CHAIN_LEN`=64, `in_valid` held high.
  - `in_ready` pulses at the cycle of bit 31.
  - `cfg_clk_en` stays 1 for 64 consecutive cycles.
- Abort at bit 20:
  - Next cycle: IDLE, `busy`=0, `cgra_hold`=1, `in_ready`=0.
  - A subsequent `start` plus a full load reaches `done`=1.
- `start` during LOAD is ignored. Simultaneous `start`+`abort` in LOAD goes to IDLE.
- With `CFG_LOADER_CHECKSUM_EN`: single 32-bit load (`CHAIN_LEN`=32) of `0x00000001` gives `checksum` = `0x80000000`. Without the macro, `checksum` is 0 throughout.
